// File: rtl/edge_evt_pkg.sv
// Shared types and defaults for the edge event arbiter slice.
package edge_evt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam int DEFAULT_N_CH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: the first set request at or after ptr,
// wrapping modulo N_CH.
module rr_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = DEFAULT_N_CH,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            any
);

  int idx_s;

  // Scan from the farthest offset back toward ptr so the nearest request wins.
  always_comb begin
    grant = {CH_W{1'b0}};
    any   = 1'b0;
    idx_s = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx_s = (int'(ptr) + k) % N_CH;
      grant = req[idx_s] ? CH_W'(idx_s) : grant;
      any   = any | req[idx_s];
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures per-channel level edges, queues one pending edge per channel and
// presents them one at a time over a valid/ready handshake in round-robin order.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = DEFAULT_N_CH,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] cfg_mask,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  state_t          state_r, state_s;
  logic [N_CH-1:0] prev_r;
  logic [N_CH-1:0] pend_r, pend_s;
  logic [N_CH-1:0] pol_r, pol_s;
  logic [N_CH-1:0] ovf_r, ovf_s;
  logic [CH_W-1:0] ptr_r, ptr_s;
  logic [CH_W-1:0] evt_ch_r, evt_ch_s;
  logic            evt_rise_r, evt_rise_s;

  logic [N_CH-1:0] edge_s;
  logic [N_CH-1:0] cap_s;
  logic [N_CH-1:0] load_vec_s;
  logic [CH_W-1:0] grant_s;
  logic            any_s;
  logic            load_s;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_rr (
    .req   (pend_r),
    .ptr   (ptr_r),
    .grant (grant_s),
    .any   (any_s)
  );

  // Edge capture, pending/polarity bookkeeping and overflow flags.
  always_comb begin
    edge_s     = in ^ prev_r;
    cap_s      = edge_s & cfg_mask;
    load_vec_s = load_s ? (N_CH'(1) << grant_s) : {N_CH{1'b0}};
    // A fresh edge on the channel being unloaded simply re-arms it; elsewhere
    // it replaces an unread edge and counts as an overflow.
    pend_s     = (pend_r & ~load_vec_s) | cap_s;
    pol_s      = (pol_r & ~cap_s) | (in & cap_s);
    ovf_s      = (ovf_clr ? {N_CH{1'b0}} : ovf_r) | (cap_s & pend_r & ~load_vec_s);
  end

  // Presentation FSM: decides when to load the next winner and what to show.
  always_comb begin
    load_s     = 1'b0;
    state_s    = state_r;
    evt_ch_s   = evt_ch_r;
    evt_rise_s = evt_rise_r;
    ptr_s      = ptr_r;
    case (state_r)
      IDLE: begin
        load_s  = any_s;
        state_s = any_s ? VALID : IDLE;
      end
      VALID: begin
        if (evt_ready) begin
          load_s  = any_s;
          state_s = any_s ? VALID : IDLE;
        end else begin
          load_s  = 1'b0;
          state_s = VALID;
        end
      end
      default: begin
        load_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
    if (load_s) begin
      evt_ch_s   = grant_s;
      evt_rise_s = pol_r[grant_s];
      ptr_s      = (grant_s == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : grant_s + CH_W'(1);
    end else begin
      evt_ch_s   = evt_ch_r;
      evt_rise_s = evt_rise_r;
      ptr_s      = ptr_r;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      prev_r     <= {N_CH{1'b0}};
      pend_r     <= {N_CH{1'b0}};
      pol_r      <= {N_CH{1'b0}};
      ovf_r      <= {N_CH{1'b0}};
      ptr_r      <= {CH_W{1'b0}};
      evt_ch_r   <= {CH_W{1'b0}};
      evt_rise_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      prev_r     <= in;
      pend_r     <= pend_s;
      pol_r      <= pol_s;
      ovf_r      <= ovf_s;
      ptr_r      <= ptr_s;
      evt_ch_r   <= evt_ch_s;
      evt_rise_r <= evt_rise_s;
    end
  end

  assign evt_valid = (state_r == VALID);
  assign evt_ch    = evt_ch_r;
  assign evt_rise  = evt_rise_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: expected events are queued as edges
// are driven and checked when the block presents them.
module tb_edge_event_arbiter;

  typedef struct packed {
    logic [1:0] ch;
    logic       rise;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [3:0] cfg_mask;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic [3:0] ovf;
  logic       ovf_clr;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  edge_event_arbiter #(
    .N_CH (4),
    .CH_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .cfg_mask  (cfg_mask),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait up to budget cycles for a presented event, then compare it to the queue head.
  task automatic pop_check(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (evt_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      e = '{ch: 2'd0, rise: 1'b0};
      vectors++;
      miscompares++;
      $error("FAIL %s: observed event with empty scoreboard ch=%0d rise=%0d", tag, evt_ch, evt_rise);
    end else begin
      e = sb.pop_front();
      vectors++;
      assert ({evt_valid, evt_ch, evt_rise} === {1'b1, e.ch, e.rise}) else begin
        miscompares++;
        $error("FAIL %s: observed valid=%0d ch=%0d rise=%0d expected valid=1 ch=%0d rise=%0d",
               tag, evt_valid, evt_ch, evt_rise, e.ch, e.rise);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in          = 4'b0000;
    cfg_mask    = 4'b1111;
    evt_ready   = 1'b0;
    ovf_clr     = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 32'({evt_valid, evt_ch, evt_rise}), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 32'(evt_valid), 32'd0);

    // Single rising edge, two-cycle latency, stable while not accepted.
    in = 4'b0100;
    sb.push_back('{ch: 2'd2, rise: 1'b1});
    tick();
    chk("latency_cycle1", 32'(evt_valid), 32'd0);
    tick();
    pop_check("first_event", 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_stable", 32'({evt_valid, evt_ch, evt_rise}), 32'b1101);
    end
    evt_ready = 1'b1;
    tick();
    chk("idle_after_accept", 32'(evt_valid), 32'd0);

    // Restart from ptr 0, then a burst of simultaneous edges.
    rst = 1'b1;
    in  = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    in = 4'b1011;
    sb.push_back('{ch: 2'd0, rise: 1'b1});
    sb.push_back('{ch: 2'd1, rise: 1'b1});
    sb.push_back('{ch: 2'd3, rise: 1'b1});
    tick();
    tick();
    pop_check("burst_rise_0", 0);
    tick();
    pop_check("burst_rise_1", 0);
    tick();
    pop_check("burst_rise_3", 0);
    tick();
    chk("burst_done", 32'(evt_valid), 32'd0);
    in = 4'b1000;
    sb.push_back('{ch: 2'd0, rise: 1'b0});
    sb.push_back('{ch: 2'd1, rise: 1'b0});
    tick();
    tick();
    pop_check("burst_fall_0", 0);
    tick();
    pop_check("burst_fall_1", 0);
    tick();
    chk("burst_fall_done", 32'(evt_valid), 32'd0);

    // Overflow: ch1 rises and falls while ch3's event is held.
    evt_ready = 1'b0;
    in = 4'b0000;
    sb.push_back('{ch: 2'd3, rise: 1'b0});
    tick();
    tick();
    pop_check("held_ch3", 0);
    in = 4'b0010;
    tick();
    in = 4'b0000;
    sb.push_back('{ch: 2'd1, rise: 1'b0});
    tick();
    chk("ovf_ch1", 32'(ovf), 32'b0010);
    evt_ready = 1'b1;
    tick();
    pop_check("ovf_delivered", 0);
    tick();
    chk("ovf_drained", 32'(evt_valid), 32'd0);

    // Masked edges are dropped; unmasking a static input raises nothing.
    cfg_mask = 4'b1011;
    in = 4'b0100;
    tick();
    in = 4'b0000;
    tick();
    in = 4'b0100;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("masked_no_event", 32'(evt_valid), 32'd0);
    end
    cfg_mask = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("unmask_static", 32'(evt_valid), 32'd0);
    end
    chk("ovf_sticky", 32'(ovf), 32'b0010);

    // ovf_clr racing a new overflow on ch3, then on its own.
    evt_ready = 1'b0;
    in = 4'b0101;
    sb.push_back('{ch: 2'd0, rise: 1'b1});
    tick();
    tick();
    pop_check("held_ch0", 0);
    in = 4'b1101;
    tick();
    in = 4'b0101;
    ovf_clr = 1'b1;
    sb.push_back('{ch: 2'd3, rise: 1'b0});
    tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins_clr", 32'(ovf), 32'b1000);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr_alone", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    tick();
    pop_check("after_clr_ch3", 0);
    tick();
    chk("clr_drained", 32'(evt_valid), 32'd0);

    // Reset while an event is presented.
    evt_ready = 1'b0;
    in = 4'b0001;
    sb.push_back('{ch: 2'd2, rise: 1'b0});
    tick();
    tick();
    pop_check("held_before_rst", 0);
    in = 4'b1001;
    tick();
    in = 4'b0001;
    tick();
    chk("ovf_before_rst", 32'(ovf), 32'b1000);
    rst = 1'b1;
    in  = 4'b0000;
    tick();
    chk("rst_drops_valid", 32'(evt_valid), 32'd0);
    chk("rst_clears_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(evt_valid), 32'd0);
    in = 4'b1010;
    sb.push_back('{ch: 2'd1, rise: 1'b1});
    sb.push_back('{ch: 2'd3, rise: 1'b1});
    evt_ready = 1'b1;
    tick();
    chk("post_rst_latency", 32'(evt_valid), 32'd0);
    tick();
    pop_check("post_rst_first", 0);
    tick();
    pop_check("post_rst_second", 0);
    tick();
    chk("post_rst_drained", 32'(evt_valid), 32'd0);

    // Edge on the channel being loaded re-arms it without overflow.
    in = 4'b1011;
    sb.push_back('{ch: 2'd0, rise: 1'b1});
    tick();
    in = 4'b1010;
    sb.push_back('{ch: 2'd0, rise: 1'b0});
    tick();
    pop_check("reload_first", 0);
    tick();
    pop_check("reload_second", 0);
    chk("reload_no_ovf", 32'(ovf), 32'd0);
    tick();
    chk("reload_drained", 32'(evt_valid), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of input channels (2..16).
REQ-002 The block SHALL have parameter CH_W, default $clog2(N_CH), meaning the channel-index width.
REQ-003 Port clk  input  1  rising-edge system clock.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in  input  N_CH  per-channel level inputs, already synchronous to clk.
REQ-006 Port cfg_mask  input  N_CH  1 = channel edges captured, 0 = edges ignored.
REQ-007 Port evt_valid  output  1  an event is presented.
REQ-008 Port evt_ready  input  1  consumer accepts the event.
REQ-009 Port evt_ch  output  CH_W  channel index of the presented event.
REQ-010 Port evt_rise  output  1  1 = rising edge, 0 = falling edge.
REQ-011 Port ovf  output  N_CH  sticky per-channel overflow flags.
REQ-012 Port ovf_clr  input  1  clears all ovf bits.

Function
REQ-013 Each channel SHALL hold prev[i], updated to in[i] every cycle regardless of mask.
REQ-014 An edge on channel i SHALL be defined as in[i] != prev[i]; polarity = in[i].
REQ-015 A masked-in edge SHALL set pend[i] and store pol[i] = in[i] at that clock edge.
REQ-016 A masked-out edge SHALL be discarded; clearing cfg_mask[i] SHALL NOT clear an existing pend[i].
REQ-017 An edge on a channel whose pend[i] is already set and not being loaded this cycle SHALL overwrite pol[i] with the new polarity and set ovf[i].
REQ-018 FSM states SHALL be IDLE and VALID; evt_valid = (state == VALID).
REQ-019 In IDLE with any pend set, the block SHALL load evt_ch/evt_rise from the round-robin winner, clear its pend, and enter VALID.
REQ-020 Round-robin search SHALL start at ptr and wrap modulo N_CH; after loading channel c, ptr SHALL become (c+1) mod N_CH.
REQ-021 In VALID, evt_ch and evt_rise SHALL remain stable until evt_valid && evt_ready.
REQ-022 On handshake with another pend set, the block SHALL load the next winner in the same cycle and stay in VALID (one event per cycle); otherwise it SHALL return to IDLE.
REQ-023 An edge on the channel being loaded in the same cycle SHALL set pend again with the new polarity, without setting ovf.
REQ-024 Latency SHALL be 2 cycles: an edge sampled at clock edge k gives evt_valid high after edge k+1 when the block is idle.
REQ-025 ovf_clr SHALL clear all ovf bits; a simultaneous set on bit i SHALL win.

Reset
REQ-026 On rst, the block SHALL clear prev, pend, pol, ovf and ptr to 0, set state to IDLE, and drive evt_valid, evt_ch and evt_rise to 0.
REQ-027 A rst asserted while in VALID SHALL drop the presented event with no handshake.

Structure
REQ-028 Package edge_evt_pkg SHALL hold the state_t enum (IDLE, VALID) and a default channel-count constant.
REQ-029 The round-robin selection SHALL be a sub-module rr_arbiter: inputs req[N_CH] and ptr; outputs grant index and any.

Verification
REQ-030 After reset, in[2] 0->1 -> evt_valid=1 two cycles later with evt_ch=2, evt_rise=1; hold evt_ready=0 for 5 cycles -> outputs stable.
REQ-031 With evt_ready=1, in[0], in[1] and in[3] rise in the same cycle -> events on ch 0, 1, 3 on consecutive cycles; then in[0] and in[1] fall -> ch 0, then 1.
REQ-032 With evt_ready=0, in[1] rises then falls while pending -> ovf[1]=1; the event delivered on release is ch 1 with evt_rise=0.
REQ-033 cfg_mask[2]=0 and in[2] toggles -> no event; unmask with in[2] static -> no event.
REQ-034 ovf_clr asserted in the same cycle as a new overflow on ch 3 -> ovf[3] stays 1; asserted alone -> ovf=0.
REQ-035 rst asserted while evt_valid=1 -> evt_valid=0 next cycle, ovf=0, and the next event is arbitrated starting from ch 0.
